async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
- Write-side controller of the NVDLA asynchronous FIFO.
- Sits directly downstream of the one-hot write clock-enable cell and consumes its `enable_w`.
- Accepts a valid/busy write stream and drives the write port of the dual-clock RAM.
- Maintains the binary/Gray write pointer, synchronizes the read-domain Gray pointer, flags full, and produces the write-side clock-gate enable. Gating is qualified by `enable_w` so DFT one-hot mode can switch the write clock off.

Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, at least 4.
- `AW`, 4: address width, equal to log2(`DEPTH`).
- `DW`, 32: payload width.
- `SYNC_STAGES`, 2: flops in the `rd_ptr_gray` synchronizer; minimum 2.

Ports:
- `wr_clk`  in  1  write-domain clock.
- `wr_reset`  in  1  asynchronous, active-high reset.
- `enable_w`  in  1  one-hot write clock enable; 1 in functional mode.
- `wr_req`  in  1  write request (valid).
- `wr_pd`  in  DW  write payload.
- `wr_busy`  out  1  write not accepted this cycle.
- `rd_ptr_gray`  in  AW+1  read pointer, Gray coded, from the read clock domain (asynchronous).
- `wr_ptr_gray`  out  AW+1  write pointer, Gray coded, registered, toward the read domain.
- `ram_we`  out  1  RAM write enable.
- `ram_wa`  out  AW  RAM write address.
- `ram_wd`  out  DW  RAM write data.
- `wr_full`  out  1  FIFO full, registered.
- `wr_clk_en`  out  1  enable for the write-domain clock gate.

Behaviour:
- Reset values (asynchronous on `wr_reset`=1):
  - All flops cleared: binary and Gray pointers, synchronizer, `ram_we`, `ram_wa`, `ram_wd`, `wr_full` are all 0.
  - `wr_busy` = 1 while `wr_reset` is high and for the first cycle after its release (the "rst_q" flop).
- Accept rule: `accept` = `wr_req` & !`wr_full` & `enable_w` & !rst_q.
- `wr_busy` = `wr_full` | !`enable_w` | rst_q. It is combinational from registers and `enable_w`, and never depends on `wr_req`.
- When `wr_busy`=1, the source holds `wr_req` and `wr_pd` stable. The block drops nothing and duplicates nothing.
- On an `accept` edge:
  - `ram_we`<=1, `ram_wa`<=wr_bin[AW-1:0], `ram_wd`<=`wr_pd`.
  - wr_bin<=wr_bin+1. The pointer is AW+1 bits and wraps modulo 2*`DEPTH`; the MSB is the lap bit.
- With no accept, `ram_we`<=0. `ram_wa`/`ram_wd` hold their last value.
- Publication delay:
  - `wr_ptr_gray`<=gray(wr_bin) is registered one cycle after wr_bin updates, so the RAM write completes before the read side sees the entry.
  - Write-to-visible latency = 2 `wr_clk` cycles plus the read-domain sync.
- Gray code: g = b ^ (b>>1). Only one bit of `wr_ptr_gray` may change per cycle.
- Read-pointer synchronizer:
  - `rd_ptr_gray` passes through `SYNC_STAGES` flops to give rd_sync.
  - No combinational logic before the first flop.
- Full detection:
  - next_bin = wr_bin + `accept`.
  - `wr_full` <= (gray(next_bin) == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]}).
  - Registered, so it updates the same edge the last slot is taken.
  - It is conservative: a stale rd_sync can only hold full longer, never clear it early.
- Simultaneous events:
  - A read freeing a slot in the same cycle as a write filling the last slot leaves `wr_full`=1 until rd_sync reflects the read (≥`SYNC_STAGES` cycles).
  - `enable_w` falling mid-stream blocks acceptance that cycle only. Pointer and RAM state hold.
- Clock gating:
  - `wr_clk_en` = `enable_w` & (`wr_req` | `ram_we` | ptr_pending | sync_pending | rst_q).
  - ptr_pending = gray(wr_bin) != `wr_ptr_gray`.
  - sync_pending = any synchronizer stage differing from its predecessor.
  - With `enable_w`=0, `wr_clk_en`=0 unconditionally.
- Reset mid-operation: all state clears immediately. Any partially published pointer returns to 0. The read side is reset together by system convention.

Optional Feature:
- Macro: `ASYNC_FIFO_WR_COUNT_EN`.
- When defined:
  - Adds output `wr_count` [AW:0] = wr_bin − gray2bin(rd_sync), registered and reset to 0.
  - Range 0..`DEPTH`, giving write-side occupancy. It may over-report by in-flight reads, never under-report.
  - `wr_clk_en` additionally stays high while `wr_count` changes.
- When not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: assert `wr_reset` mid-burst (`wr_req`=1), release.
  - Required: all outputs 0, `wr_busy`=1 during reset and 1 cycle after. The first accept lands at `ram_wa`=0 with `wr_ptr_gray` 0→1.
- Fill:
  - Stimulus: `DEPTH`=16, `rd_ptr_gray` held 0, 20 back-to-back `wr_req`.
  - Required: exactly 16 `ram_we` pulses at addresses 0..15. `wr_full` rises on the edge of the 16th accept. `wr_busy`=1 afterwards, final `wr_ptr_gray`=5'b11000.
- Drain-release:
  - Stimulus: from full, step `rd_ptr_gray` to 5'b00001.
  - Required: `wr_full` clears exactly `SYNC_STAGES`+1 cycles later. The next write uses `ram_wa`=0 and `wr_ptr_gray`=5'b11001.
- Wrap:
  - Stimulus: 40 writes with a read pointer tracking 2 behind.
  - Required: addresses wrap 15→0. The lap bit toggles at 16 and 32. Every `wr_ptr_gray` transition changes 1 bit (bench checker).
- DFT one-hot:
  - Stimulus: `enable_w`=0 with `wr_req`=1 for 5 cycles.
  - Required: `wr_clk_en`=0, `wr_busy`=1, no `ram_we`, pointers unchanged. Restoring `enable_w`=1 produces the accept the next edge.
- Count (with `ASYNC_FIFO_WR_COUNT_EN`):
  - Stimulus: 7 writes, then `rd_ptr_gray`=gray(3).
  - Required: `wr_count` reaches 7, then 4 after the sync delay.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl
// Description : Write-side controller of the dual-clock FIFO. It accepts a
//               valid/busy write stream and drives the RAM write port. It keeps
//               the binary and Gray write pointers, synchronises the read
//               pointer, flags full, and produces the write clock-gate enable.
//               The gate enable is qualified by the one-hot enable_w.
// Options     : `define ASYNC_FIFO_WR_COUNT_EN adds the registered wr_count
//               occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          wr_clk,
  input  logic          wr_reset,
  input  logic          enable_w,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_pd,
  output logic          wr_busy,
  input  logic [AW:0]   rd_ptr_gray,
  output logic [AW:0]   wr_ptr_gray,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_wd,
  output logic          wr_full,
  output logic          wr_clk_en
`ifdef ASYNC_FIFO_WR_COUNT_EN
  ,
  output logic [AW:0]   wr_count
`endif
);

  // Elaboration guard on the geometry: DEPTH must be 2**AW, at least 4, and the
  // synchroniser needs two flops or more.
  if (DEPTH != (1 << AW) || DEPTH < 4 || SYNC_STAGES < 2) begin : g_param_check
    $error("async_fifo_wr_ctrl: illegal DEPTH/AW/SYNC_STAGES combination");
  end

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic                         rst_q;
  logic [AW:0]                  wr_bin_q;
  logic [AW:0]                  wr_bin_d;
  logic [AW:0]                  wr_gray_q;
  logic [SYNC_STAGES-1:0][AW:0] sync_q;
  logic [AW:0]                  rd_sync;
  logic                         ram_we_q;
  logic [AW-1:0]                ram_wa_q;
  logic [DW-1:0]                ram_wd_q;
  logic                         wr_full_q;
  logic                         wr_full_d;
  logic [AW:0]                  full_match;
  logic                         accept;
  logic                         ptr_pending;
  logic                         sync_pending;
  logic                         cnt_pending;

  // The reset tail flop stays set through reset and for one cycle after release.
  // This keeps the write port busy while the read side comes out of reset.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
    end
  end

  // Plain flop chain for the asynchronous read pointer. Stage 0 samples the raw
  // input directly.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rd_sync  = sync_q[SYNC_STAGES-1];
  assign accept   = wr_req & ~wr_full_q & enable_w & ~rst_q;
  assign wr_bin_d = wr_bin_q + {{AW{1'b0}}, accept};

  // Full means the write pointer is one lap ahead of the read pointer. In Gray
  // code that is the read pointer with its top two bits inverted.
  assign full_match = {~rd_sync[AW:AW-1], rd_sync[AW-2:0]};
  assign wr_full_d  = (bin2gray(wr_bin_d) == full_match);

  // Pointer, RAM port and full flag. The Gray pointer is published one cycle
  // after the binary pointer moves, so the RAM write lands before the read
  // side can see it.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      ram_we_q  <= 1'b0;
      ram_wa_q  <= '0;
      ram_wd_q  <= '0;
      wr_full_q <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= bin2gray(wr_bin_q);
      ram_we_q  <= accept;
      if (accept) begin
        ram_wa_q <= wr_bin_q[AW-1:0];
        ram_wd_q <= wr_pd;
      end
      wr_full_q <= wr_full_d;
    end
  end

  // Flag a change still travelling down the synchroniser. The raw input is
  // deliberately not compared, so the asynchronous pin never reaches the
  // gate enable.
  always_comb begin
    sync_pending = 1'b0;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      if (sync_q[i] != sync_q[i-1]) begin
        sync_pending = 1'b1;
      end
    end
  end

  assign ptr_pending = (bin2gray(wr_bin_q) != wr_gray_q);

`ifdef ASYNC_FIFO_WR_COUNT_EN
  logic [AW:0] wr_count_q;
  logic [AW:0] wr_count_d;

  // Occupancy as seen from the write side. A stale read pointer can only
  // over-report.
  assign wr_count_d  = wr_bin_q - gray2bin(rd_sync);
  assign cnt_pending = (wr_count_d != wr_count_q);

  // Occupancy register.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`else
  assign cnt_pending = 1'b0;
`endif

  assign wr_busy     = wr_full_q | ~enable_w | rst_q;
  assign wr_clk_en   = enable_w &
                       (wr_req | ram_we_q | ptr_pending | sync_pending | rst_q | cnt_pending);
  assign wr_ptr_gray = wr_gray_q;
  assign ram_we      = ram_we_q;
  assign ram_wa      = ram_wa_q;
  assign ram_wd      = ram_wd_q;
  assign wr_full     = wr_full_q;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_ctrl
// Description : Self-checking bench for async_fifo_wr_ctrl. An occupancy-level
//               reference model is compared every cycle, and directed phases
//               pin literal expectations. Building with
//               ASYNC_FIFO_WR_COUNT_EN also checks wr_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int SS    = 2;

  logic          wr_clk      = 1'b0;
  logic          wr_reset    = 1'b0;
  logic          enable_w    = 1'b1;
  logic          wr_req      = 1'b0;
  logic [DW-1:0] wr_pd       = '0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic          wr_busy;
  logic [AW:0]   wr_ptr_gray;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;
  logic          wr_full;
  logic          wr_clk_en;
`ifdef ASYNC_FIFO_WR_COUNT_EN
  logic [AW:0]   wr_count;
`endif

  async_fifo_wr_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .SYNC_STAGES(SS)
  ) dut (
    .wr_clk(wr_clk), .wr_reset(wr_reset), .enable_w(enable_w),
    .wr_req(wr_req), .wr_pd(wr_pd), .wr_busy(wr_busy),
    .rd_ptr_gray(rd_ptr_gray), .wr_ptr_gray(wr_ptr_gray),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd),
    .wr_full(wr_full), .wr_clk_en(wr_clk_en)
`ifdef ASYNC_FIFO_WR_COUNT_EN
    , .wr_count(wr_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    logic        acc;
    acc = 1'b0;
    for (int i = AW; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // ---------------- reference model (occupancy arithmetic) ----------------
  logic                m_rst  = 1'b1;
  logic [AW:0]         m_wn   = '0;   // writes accepted, modulo 2*DEPTH
  logic [AW:0]         m_pub  = '0;   // writes visible on wr_ptr_gray
  logic [SS-1:0][AW:0] m_hist = '0;   // read pointer samples, newest at [0]
  logic                m_full = 1'b0;
  logic                m_we   = 1'b0;
  logic [AW-1:0]       m_wa   = '0;
  logic [DW-1:0]       m_wd   = '0;
  logic                m_acc;
  logic [AW:0]         m_occ_now;
  logic [AW:0]         m_occ_next;
  logic                m_sp;
`ifdef ASYNC_FIFO_WR_COUNT_EN
  logic [AW:0]         m_cnt  = '0;
`endif

  assign m_acc      = wr_req && !m_full && enable_w && !m_rst;
  assign m_occ_now  = m_wn - g2b(m_hist[SS-1]);
  assign m_occ_next = m_occ_now + (AW+1)'(m_acc);

  always_comb begin
    m_sp = 1'b0;
    for (int k = 1; k < SS; k++) begin
      if (m_hist[k] != m_hist[k-1]) m_sp = 1'b1;
    end
  end

  always @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      m_rst  <= 1'b1;
      m_wn   <= '0;
      m_pub  <= '0;
      m_hist <= '0;
      m_full <= 1'b0;
      m_we   <= 1'b0;
      m_wa   <= '0;
      m_wd   <= '0;
`ifdef ASYNC_FIFO_WR_COUNT_EN
      m_cnt  <= '0;
`endif
    end else begin
      m_rst  <= 1'b0;
      m_pub  <= m_wn;
      m_wn   <= m_wn + (AW+1)'(m_acc);
      m_full <= (m_occ_next == (AW+1)'(DEPTH));
      m_we   <= m_acc;
      if (m_acc) begin
        m_wa <= m_wn[AW-1:0];
        m_wd <= wr_pd;
      end
      m_hist <= {m_hist[SS-2:0], rd_ptr_gray};
`ifdef ASYNC_FIFO_WR_COUNT_EN
      m_cnt  <= m_occ_now;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [AW:0] prev_g = '0;
  always @(negedge wr_clk) begin
    #1;
    check("wr_busy", wr_busy, m_full | !enable_w | m_rst);
    check("wr_clk_en", wr_clk_en, enable_w & (wr_req | m_we | (m_wn != m_pub) | m_sp | m_rst
`ifdef ASYNC_FIFO_WR_COUNT_EN
          | (m_occ_now != m_cnt)
`endif
          ));
    check("ram_we", ram_we, m_we);
    check("ram_wa", ram_wa, m_wa);
    check("ram_wd", ram_wd, m_wd);
    check("wr_full", wr_full, m_full);
    check("wr_ptr_gray", wr_ptr_gray, gray(int'(m_pub)));
`ifdef ASYNC_FIFO_WR_COUNT_EN
    check("wr_count", wr_count, m_cnt);
`endif
    if (wr_reset) begin
      prev_g <= '0;
    end else begin
      check("gray_one_bit", ($countones(wr_ptr_gray ^ prev_g) <= 1), 1'b1);
      prev_g <= wr_ptr_gray;
    end
  end

  // ---------------- stimulus ----------------
  logic        last_acc = 1'b0;
  logic [AW:0] rd_n     = '0;

  // One cycle. The source may only change its request after an accept.
  task automatic step();
    last_acc = wr_req && !wr_busy;
    @(negedge wr_clk);
    #2;
  endtask

  task automatic drive_req(input logic req);
    if (last_acc || !wr_req) begin
      wr_req = req;
      wr_pd  = $urandom;
    end
  endtask

  task automatic do_reset();
    wr_reset    = 1'b1;
    wr_req      = 1'b0;
    enable_w    = 1'b1;
    rd_n        = '0;
    rd_ptr_gray = '0;
    step();
    step();
    wr_reset = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    int          n;
    int          writes;
    int          laps;
    logic        prev_lap;
    logic [DW-1:0] held_pd;
    logic [AW:0] g0;

    // ---- reset, including a reset during a burst ----
    #1;
    wr_reset = 1'b1;
    wr_req   = 1'b1;
    wr_pd    = $urandom;
    repeat (3) step();
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_wptr", wr_ptr_gray, 5'b00000);
    check("rst_full", wr_full, 1'b0);
    check("rst_busy", wr_busy, 1'b1);
    wr_reset = 1'b0;
    check("busy_at_release", wr_busy, 1'b1);
    step();
    check("busy_after_tail", wr_busy, 1'b0);
    check("no_write_in_tail", ram_we, 1'b0);
    drive_req(1'b1);
    step();
    check("first_we", ram_we, 1'b1);
    check("first_wa", ram_wa, 4'd0);
    check("first_wptr_before", wr_ptr_gray, 5'b00000);
    drive_req(1'b1);
    step();
    check("first_wptr_after", wr_ptr_gray, 5'b00001);
    drive_req(1'b1);
    step();
    drive_req(1'b1);
    step();
    wr_reset = 1'b1;
    #1;
    check("midrst_we", ram_we, 1'b0);
    check("midrst_wptr", wr_ptr_gray, 5'b00000);
    check("midrst_wa", ram_wa, 4'd0);
    check("midrst_busy", wr_busy, 1'b1);
    step();
    step();
    wr_reset = 1'b0;
    step();

    // ---- fill with the read pointer held at 0 ----
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive_req(1'b1);
      step();
      if (ram_we) begin
        check("fill_addr", ram_wa, pulses[AW-1:0]);
        check("fill_full_edge", wr_full, (pulses == DEPTH - 1));
        pulses++;
      end
    end
    check("fill_pulses", pulses, 16);
    check("fill_wptr", wr_ptr_gray, 5'b11000);
    check("fill_busy", wr_busy, 1'b1);

    // ---- release one slot from full ----
    held_pd     = wr_pd;
    rd_ptr_gray = 5'b00001;
    n = 0;
    do begin
      step();
      n++;
    end while (wr_full && n < 10);
    check("drain_latency", n, SS + 1);
    drive_req(1'b1);
    step();
    check("drain_we", ram_we, 1'b1);
    check("drain_wa", ram_wa, 4'd0);
    check("drain_wd", ram_wd, held_pd);
    drive_req(1'b0);
    step();
    check("drain_wptr", wr_ptr_gray, 5'b11001);

    // ---- wrap with the reader two behind ----
    do_reset();
    writes   = 0;
    laps     = 0;
    prev_lap = wr_ptr_gray[AW];
    n        = 0;
    while (writes < 40 && n < 200) begin
      drive_req(1'b1);
      rd_ptr_gray = gray((writes >= 2) ? writes - 2 : 0);
      step();
      n++;
      if (ram_we) begin
        check("wrap_addr", ram_wa, (writes % DEPTH));
        writes++;
      end
      if (wr_ptr_gray[AW] != prev_lap) laps++;
      prev_lap = wr_ptr_gray[AW];
    end
    drive_req(1'b0);
    repeat (2) begin
      step();
      if (wr_ptr_gray[AW] != prev_lap) laps++;
      prev_lap = wr_ptr_gray[AW];
    end
    check("wrap_writes", writes, 40);
    check("wrap_lap_toggles", laps, 2);
    check("wrap_wptr", wr_ptr_gray, 5'b01100);

    // ---- DFT one-hot mode blocks the port ----
    repeat (3) step();
    g0 = wr_ptr_gray;
    drive_req(1'b1);
    enable_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("dft_clk_en", wr_clk_en, 1'b0);
      check("dft_busy", wr_busy, 1'b1);
      check("dft_we", ram_we, 1'b0);
      check("dft_wptr", wr_ptr_gray, g0);
    end
    enable_w = 1'b1;
    drive_req(1'b1);
    step();
    check("dft_restore_we", ram_we, 1'b1);

    // ---- randomized traffic ----
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable_w = ($urandom_range(0, 7) != 0);
      drive_req($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0 && rd_n != m_pub) rd_n = rd_n + 1'b1;
      rd_ptr_gray = gray(int'(rd_n));
      step();
    end
    enable_w = 1'b1;

`ifdef ASYNC_FIFO_WR_COUNT_EN
    // ---- occupancy count ----
    do_reset();
    writes = 0;
    n      = 0;
    while (writes < 7 && n < 30) begin
      drive_req(1'b1);
      step();
      n++;
      if (ram_we) writes++;
    end
    drive_req(1'b0);
    repeat (3) step();
    check("count_seven", wr_count, 5'd7);
    rd_ptr_gray = gray(3);
    n = 0;
    do begin
      step();
      n++;
    end while (wr_count != 5'd4 && n < 10);
    check("count_four", wr_count, 5'd4);
    check("count_latency", n, SS + 1);
`endif

    drive_req(1'b0);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
